mmio_timer_responder: RTL and testbench
=======================================

Name: mmio_timer_responder

Overview:
Memory-mapped responder on the CPU data-memory bus, sitting beside data_memory and answering a fixed address window. It provides:
- a 64-bit machine timer (mtime) with a prescaler;
- a 64-bit compare register (mtimecmp) driving a timer interrupt;
- a status register and a scratch "tohost" register for program-visible test results.

The top level ORs mem_data_out with data_memory's output, gated by mmio_hit.

Parameters:
- BASE_ADDR, 32'h1000_0000, window base; bits [7:0] must be zero; window is 256 bytes.
- MTIMECMP_RST, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- wr_en  in  1  store strobe, same as data_memory wr_en.
- mem_ctrl  in  mem_op_t  access size/sign: LB/LH/LW/LBU/LHU/SB/SH/SW.
- addr  in  32  byte address.
- data_in  in  32  store data, right-aligned.
- data_out  out  32  load data, extended per mem_ctrl; 0 when not hit.
- mmio_hit  out  1  addr[31:8] == BASE_ADDR[31:8]; combinational.
- irq_timer  out  1  registered timer interrupt.

Behaviour:
Register map (offset = addr[7:0]):
- 0x00 MTIME_LO, 0x04 MTIME_HI.
- 0x08 CMP_LO, 0x0C CMP_HI.
- 0x10 CTRL: bit0 EN, bit1 IRQ_EN, bits[15:8] PRESCALE.
- 0x14 STATUS: bit0 PEND (write-1-to-clear), bit1 ALIGN_ERR (write-1-to-clear).
- 0x18 TOHOST.
- All other offsets read 0; writes to them are ignored.

Access timing:
- Reads are combinational, returning data in the same cycle as addr/mem_ctrl, matching data_memory.
- Writes commit on the rising clk edge when wr_en && mmio_hit.
- Byte/half lanes: SB writes lane addr[1:0]; SH writes lane addr[1]; SW writes the whole word.
- LB/LH return the selected lane sign-extended. LBU/LHU zero-extend it.

Prescaler:
- pcnt is 8 bits. When EN=1: if pcnt == PRESCALE, pcnt <= 0 and tick=1; else pcnt <= pcnt+1.
- EN=0 holds pcnt and mtime.
- PRESCALE=0 gives a tick every cycle.

mtime:
- Increments by 1 on tick and wraps modulo 2^64.
- Carry from LO into HI completes in the same cycle.
- A store to MTIME_LO or MTIME_HI in the same cycle as a tick: the store wins for the written half. The other half holds (no increment that cycle).

Hi snapshot:
- On any clock edge with a load (wr_en=0) hitting offset 0x00, shadow_hi <= mtime[63:32] as seen in that cycle.
- Reads of MTIME_HI return shadow_hi, not live mtime.
- Software sequence "LW LO; LW HI" is therefore tear-free.

Compare:
- PEND <= 1 on any edge where EN && (mtime >= mtimecmp), unsigned 64-bit.
- PEND is sticky.
- W1C of PEND in the same cycle as a true compare: set wins.
- irq_timer <= PEND && IRQ_EN (registered; one cycle after PEND rises).

Reset values (asynchronous):
- mtime 0, pcnt 0, mtimecmp MTIMECMP_RST.
- CTRL 0, STATUS 0, TOHOST 0, shadow_hi 0, irq_timer 0.
- Reset mid-count discards all state. The first tick after release needs PRESCALE+1 enabled cycles.

Optional Feature:
MMIO_TIMER_ALIGN_CHECK_EN
- Defined:
  - LW/SW with addr[1:0] != 0, and LH/LHU/SH with addr[0] != 0, are misaligned.
  - Misaligned stores are dropped and set ALIGN_ERR on that edge.
  - Misaligned loads return 0.
- Undefined:
  - Word accesses ignore addr[1:0]; half accesses ignore addr[0], i.e. force-aligned.
  - ALIGN_ERR reads 0 and never sets.

Decomposition:
- New package mmio_timer_pkg holds:
  - offset localparams (OFF_MTIME_LO … OFF_TOHOST);
  - CTRL/STATUS bit indices;
  - PRESCALE field position;
  - lane extract/extend and lane-merge functions.
- mem_op_t is reused from control_types_pkg.
- One sub-module, mtime_counter:
  - prescaler + 64-bit counter;
  - load ports for lo/hi;
  - tick output.

Test Plan:
1. Reset, then read every offset -> CMP_LO/CMP_HI = FFFFFFFF, all others 0; irq_timer=0; mmio_hit=0 for addr 32'h0000_0100.
2. SW CTRL=0x0000_0001 (EN, PRESCALE=0), wait 10 cycles, LW MTIME_LO -> value within 10..12; SW CTRL=0x0000_0301 -> MTIME_LO advances by 1 per 4 cycles.
3. SW MTIME_LO=FFFFFFFE, MTIME_HI=0, EN=1, PRESCALE=0; after 3 ticks -> LW LO then LW HI returns HI=1, LO=1; HI read equals the snapshot taken at the LO load.
4. SW CMP_LO=20, CMP_HI=0, CTRL=0x3 -> PEND=1 when mtime reaches 20; irq_timer rises exactly 1 cycle later; SW STATUS=1 while mtime>=cmp -> PEND stays 1; SW CMP_HI=1, then STATUS=1 -> PEND=0, irq_timer=0 next cycle.
5. SB 0xAA to TOHOST+1 over 0x12345678 -> TOHOST=0x1234AA78; LB TOHOST+1 -> 0xFFFFFFAA; LBU -> 0x000000AA; LH TOHOST+2 -> 0x00001234.
6. With MMIO_TIMER_ALIGN_CHECK_EN: SW 0xDEADBEEF to TOHOST+2 -> TOHOST unchanged, ALIGN_ERR=1; LW TOHOST+1 -> 0. Without the macro: the same store writes TOHOST=0xDEADBEEF.

Source files
------------

// File: rtl/control_types_pkg.sv
// Shared CPU control types; mem_op_t encodes data-memory access size and sign.
package control_types_pkg;

    typedef enum logic [3:0] {
        MEM_LB  = 4'd0,
        MEM_LH  = 4'd1,
        MEM_LW  = 4'd2,
        MEM_LBU = 4'd3,
        MEM_LHU = 4'd4,
        MEM_SB  = 4'd5,
        MEM_SH  = 4'd6,
        MEM_SW  = 4'd7
    } mem_op_t;

endpackage

// File: rtl/mmio_timer_pkg.sv
// Register map, field positions and byte-lane helpers for mmio_timer_responder.
package mmio_timer_pkg;
    import control_types_pkg::*;

    localparam logic [7:0] OFF_MTIME_LO = 8'h00;
    localparam logic [7:0] OFF_MTIME_HI = 8'h04;
    localparam logic [7:0] OFF_CMP_LO   = 8'h08;
    localparam logic [7:0] OFF_CMP_HI   = 8'h0C;
    localparam logic [7:0] OFF_CTRL     = 8'h10;
    localparam logic [7:0] OFF_STATUS   = 8'h14;
    localparam logic [7:0] OFF_TOHOST   = 8'h18;

    localparam int CTRL_EN_BIT       = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int PRESCALE_LSB      = 8;
    localparam int PRESCALE_W        = 8;
    localparam int STATUS_PEND_BIT   = 0;
    localparam int STATUS_ALIGN_BIT  = 1;

    // Only EN, IRQ_EN and PRESCALE are storage; other CTRL bits read 0.
    localparam logic [31:0] CTRL_MASK = 32'h0000_FF03;

    function automatic logic is_load(input mem_op_t op);
        logic r;
        case (op)
            MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] boff);
        logic r;
        case (op)
            MEM_LW, MEM_SW:          r = (boff != 2'b00);
            MEM_LH, MEM_LHU, MEM_SH: r = boff[0];
            default:                 r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input mem_op_t op,
                                                 input logic [1:0] boff);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (boff)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        h = boff[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  r = {{24{b[7]}}, b};
            MEM_LBU: r = {24'h00_0000, b};
            MEM_LH:  r = {{16{h[15]}}, h};
            MEM_LHU: r = {16'h0000, h};
            MEM_LW:  r = word;
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] wdata,
                                               input mem_op_t op, input logic [1:0] boff);
        logic [31:0] r;
        r = old;
        case (op)
            MEM_SB: begin
                case (boff)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r        = old;
                endcase
            end
            MEM_SH: begin
                if (boff[1]) r[31:16] = wdata[15:0];
                else         r[15:0]  = wdata[15:0];
            end
            MEM_SW:  r = wdata;
            default: r = old;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mtime_counter.sv
// Prescaled 64-bit machine timer with independent lo/hi load ports.
module mtime_counter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en_i,
    input  logic [7:0]  prescale_i,
    input  logic        ld_lo_i,
    input  logic        ld_hi_i,
    input  logic [31:0] ld_data_i,
    output logic [63:0] mtime_o,
    output logic        tick_o
);
    logic [7:0]  pcnt_q, pcnt_d;
    logic [63:0] mtime_q, mtime_d;
    logic        tick_s;

    // Prescaler and counter next state; a load freezes the half it does not write.
    always_comb begin
        tick_s = en_i && (pcnt_q == prescale_i);
        pcnt_d = pcnt_q;
        if (en_i) begin
            pcnt_d = tick_s ? 8'h00 : (pcnt_q + 8'h01);
        end else begin
            pcnt_d = pcnt_q;
        end
        mtime_d = mtime_q;
        if (ld_lo_i || ld_hi_i) begin
            mtime_d[31:0]  = ld_lo_i ? ld_data_i : mtime_q[31:0];
            mtime_d[63:32] = ld_hi_i ? ld_data_i : mtime_q[63:32];
        end else if (tick_s) begin
            mtime_d = mtime_q + 64'd1;
        end else begin
            mtime_d = mtime_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q  <= 8'h00;
            mtime_q <= 64'd0;
        end else begin
            pcnt_q  <= pcnt_d;
            mtime_q <= mtime_d;
        end
    end

    assign mtime_o = mtime_q;
    assign tick_o  = tick_s;

endmodule

// File: rtl/mmio_timer_responder.sv
// MMIO timer/compare/tohost responder on the data-memory bus.
// Define MMIO_TIMER_ALIGN_CHECK_EN to drop misaligned accesses and flag ALIGN_ERR.
module mmio_timer_responder
    import control_types_pkg::*;
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h1000_0000,
    parameter logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wr_en,
    input  mem_op_t     mem_ctrl,
    input  logic [31:0] addr,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic        mmio_hit,
    output logic        irq_timer
);
    logic [7:0]  word_off_s;
    logic [1:0]  boff_s;
    logic        misalign_s, align_set_s, wr_hit_s, ld_hit_s;
    logic        wr_mlo_s, wr_mhi_s, wr_clo_s, wr_chi_s, wr_ctrl_s, wr_stat_s, wr_host_s;
    logic [31:0] raw_word_s, rd_word_s, merged_s, clr_s;
    logic [63:0] mtime_s;
    logic        cnt_tick_unused_s;
    logic        en_s, irq_en_s, cmp_hit_s;

    logic [63:0] cmp_q;
    logic [31:0] ctrl_q, tohost_q, shadow_q;
    logic        pend_q, align_q, irq_q;

    assign mmio_hit   = (addr[31:8] == BASE_ADDR[31:8]);
    assign word_off_s = {addr[7:2], 2'b00};
    assign boff_s     = addr[1:0];

`ifdef MMIO_TIMER_ALIGN_CHECK_EN
    assign misalign_s  = is_misaligned(mem_ctrl, boff_s);
    assign align_set_s = wr_en && mmio_hit && misalign_s;
`else
    assign misalign_s  = 1'b0;
    assign align_set_s = 1'b0;
`endif

    assign wr_hit_s  = wr_en && mmio_hit && !misalign_s;
    assign ld_hit_s  = !wr_en && mmio_hit && is_load(mem_ctrl);
    assign wr_mlo_s  = wr_hit_s && (word_off_s == OFF_MTIME_LO);
    assign wr_mhi_s  = wr_hit_s && (word_off_s == OFF_MTIME_HI);
    assign wr_clo_s  = wr_hit_s && (word_off_s == OFF_CMP_LO);
    assign wr_chi_s  = wr_hit_s && (word_off_s == OFF_CMP_HI);
    assign wr_ctrl_s = wr_hit_s && (word_off_s == OFF_CTRL);
    assign wr_stat_s = wr_hit_s && (word_off_s == OFF_STATUS);
    assign wr_host_s = wr_hit_s && (word_off_s == OFF_TOHOST);

    assign en_s      = ctrl_q[CTRL_EN_BIT];
    assign irq_en_s  = ctrl_q[CTRL_IRQ_EN_BIT];
    assign cmp_hit_s = en_s && (mtime_s >= cmp_q);

    mtime_counter u_mtime (
        .clk        (clk),
        .rst_n      (resetn),
        .en_i       (en_s),
        .prescale_i (ctrl_q[PRESCALE_LSB +: PRESCALE_W]),
        .ld_lo_i    (wr_mlo_s),
        .ld_hi_i    (wr_mhi_s),
        .ld_data_i  (merged_s),
        .mtime_o    (mtime_s),
        .tick_o     (cnt_tick_unused_s)
    );

    // Register read mux; writes merge against live values, loads of MTIME_HI see the snapshot.
    always_comb begin
        case (word_off_s)
            OFF_MTIME_LO: raw_word_s = mtime_s[31:0];
            OFF_MTIME_HI: raw_word_s = mtime_s[63:32];
            OFF_CMP_LO:   raw_word_s = cmp_q[31:0];
            OFF_CMP_HI:   raw_word_s = cmp_q[63:32];
            OFF_CTRL:     raw_word_s = ctrl_q;
            OFF_STATUS:   raw_word_s = {30'h0, align_q, pend_q};
            OFF_TOHOST:   raw_word_s = tohost_q;
            default:      raw_word_s = 32'h0000_0000;
        endcase
        if (word_off_s == OFF_MTIME_HI) begin
            rd_word_s = shadow_q;
        end else begin
            rd_word_s = raw_word_s;
        end
        merged_s = lane_merge(raw_word_s, data_in, mem_ctrl, boff_s);
        clr_s    = lane_merge(32'h0000_0000, data_in, mem_ctrl, boff_s);
        if (ld_hit_s && !misalign_s) begin
            data_out = lane_extract(rd_word_s, mem_ctrl, boff_s);
        end else begin
            data_out = 32'h0000_0000;
        end
    end

    // Software-visible registers; a new compare/alignment event outranks a same-cycle W1C.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cmp_q    <= MTIMECMP_RST;
            ctrl_q   <= 32'h0000_0000;
            tohost_q <= 32'h0000_0000;
            shadow_q <= 32'h0000_0000;
            pend_q   <= 1'b0;
            align_q  <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_clo_s)  cmp_q[31:0]  <= merged_s;
            if (wr_chi_s)  cmp_q[63:32] <= merged_s;
            if (wr_ctrl_s) ctrl_q       <= merged_s & CTRL_MASK;
            if (wr_host_s) tohost_q     <= merged_s;
            if (ld_hit_s && (word_off_s == OFF_MTIME_LO)) shadow_q <= mtime_s[63:32];
            pend_q  <= cmp_hit_s   || (pend_q  && !(wr_stat_s && clr_s[STATUS_PEND_BIT]));
            align_q <= align_set_s || (align_q && !(wr_stat_s && clr_s[STATUS_ALIGN_BIT]));
            irq_q   <= pend_q && irq_en_s;
        end
    end

    assign irq_timer = irq_q;

endmodule

// File: tb/tb_mmio_timer_responder.sv
// Directed bench for mmio_timer_responder; honours MMIO_TIMER_ALIGN_CHECK_EN.
module tb_mmio_timer_responder;
    import control_types_pkg::*;

    localparam logic [31:0] B = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wr_en;
    mem_op_t     mem_ctrl;
    logic [31:0] addr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        mmio_hit;
    logic        irq_timer;

    int errors = 0;
    int checks = 0;

    mmio_timer_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .wr_en     (wr_en),
        .mem_ctrl  (mem_ctrl),
        .addr      (addr),
        .data_in   (data_in),
        .data_out  (data_out),
        .mmio_hit  (mmio_hit),
        .irq_timer (irq_timer)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        resetn   = 1'b0;
        wr_en    = 1'b0;
        mem_ctrl = MEM_LW;
        addr     = 32'h0;
        data_in  = 32'h0;
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic wr(input logic [7:0] off, input mem_op_t op, input logic [31:0] d);
        addr     = B | {24'h0, off};
        mem_ctrl = op;
        data_in  = d;
        wr_en    = 1'b1;
        @(posedge clk);
        #1;
        wr_en    = 1'b0;
        mem_ctrl = MEM_LW;
        addr     = 32'h0;
    endtask

    task automatic rd(input logic [7:0] off, input mem_op_t op, output logic [31:0] d);
        addr     = B | {24'h0, off};
        mem_ctrl = op;
        wr_en    = 1'b0;
        #1;
        d = data_out;
        @(posedge clk);
        #1;
        addr = 32'h0;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] exp_v;
        logic        found;
        int          cnt;

        // 1: reset values
        do_reset();
        for (int o = 0; o <= 28; o += 4) begin
            exp_v = (o == 8 || o == 12) ? 32'hFFFF_FFFF : 32'h0;
            rd(o[7:0], MEM_LW, v);
            check($sformatf("reset_off_%0h", o), v, exp_v);
        end
        rd(8'h40, MEM_LW, v);
        check("unmapped_read", v, 32'h0);
        check("reset_irq", {31'h0, irq_timer}, 32'h0);
        addr = 32'h0000_0100;
        #1;
        check("hit_outside", {31'h0, mmio_hit}, 32'h0);
        check("data_outside", data_out, 32'h0);
        addr = B | 32'h0000_00FC;
        #1;
        check("hit_inside", {31'h0, mmio_hit}, 32'h1);

        // 2: counting with PRESCALE=0 then PRESCALE=3
        do_reset();
        wr(8'h10, MEM_SW, 32'h0000_0001);
        repeat (10) @(posedge clk);
        #1;
        rd(8'h00, MEM_LW, v);
        check("mtime_after_10", v, 32'd10);
        wr(8'h10, MEM_SW, 32'h0000_0301);
        rd(8'h00, MEM_LW, v);
        check("mtime_pre3_a", v, 32'd12);
        repeat (3) @(posedge clk);
        #1;
        rd(8'h00, MEM_LW, v);
        check("mtime_pre3_b", v, 32'd13);
        repeat (3) @(posedge clk);
        #1;
        rd(8'h00, MEM_LW, v);
        check("mtime_pre3_c", v, 32'd14);
        rd(8'h10, MEM_LW, v);
        check("ctrl_readback", v, 32'h0000_0301);

        // 3: carry into HI and tear-free snapshot
        do_reset();
        wr(8'h00, MEM_SW, 32'hFFFF_FFFE);
        wr(8'h04, MEM_SW, 32'h0000_0000);
        wr(8'h10, MEM_SW, 32'h0000_0001);
        repeat (3) @(posedge clk);
        #1;
        rd(8'h00, MEM_LW, v);
        check("carry_lo", v, 32'h0000_0001);
        rd(8'h04, MEM_LW, v);
        check("carry_hi_snap", v, 32'h0000_0001);

        // 4: compare, sticky PEND, irq latency, W1C
        do_reset();
        wr(8'h08, MEM_SW, 32'd20);
        wr(8'h0C, MEM_SW, 32'd0);
        wr(8'h10, MEM_SW, 32'h0000_0003);
        addr     = B | 32'h0000_0014;
        mem_ctrl = MEM_LW;
        found    = 1'b0;
        cnt      = 0;
        for (int i = 1; i <= 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (data_out[0]) begin
                found = 1'b1;
                cnt   = i;
            end
        end
        check("pend_cycle", cnt, 32'd21);
        check("irq_not_yet", {31'h0, irq_timer}, 32'h0);
        @(posedge clk);
        #1;
        check("irq_rises", {31'h0, irq_timer}, 32'h1);
        wr(8'h14, MEM_SW, 32'h0000_0001);
        rd(8'h14, MEM_LW, v);
        check("pend_set_wins", v, 32'h0000_0001);
        wr(8'h0C, MEM_SW, 32'h0000_0001);
        wr(8'h14, MEM_SW, 32'h0000_0001);
        rd(8'h14, MEM_LW, v);
        check("pend_cleared", v, 32'h0);
        check("irq_cleared", {31'h0, irq_timer}, 32'h0);

        // 5: byte/half lanes on TOHOST
        do_reset();
        wr(8'h18, MEM_SW, 32'h1234_5678);
        wr(8'h19, MEM_SB, 32'h0000_00AA);
        rd(8'h18, MEM_LW, v);
        check("sb_merge", v, 32'h1234_AA78);
        rd(8'h19, MEM_LB, v);
        check("lb_sext", v, 32'hFFFF_FFAA);
        rd(8'h19, MEM_LBU, v);
        check("lbu_zext", v, 32'h0000_00AA);
        rd(8'h1A, MEM_LH, v);
        check("lh_upper", v, 32'h0000_1234);
        rd(8'h18, MEM_LHU, v);
        check("lhu_lower", v, 32'h0000_AA78);

        // 6: misaligned word store
        wr(8'h1A, MEM_SW, 32'hDEAD_BEEF);
`ifdef MMIO_TIMER_ALIGN_CHECK_EN
        rd(8'h18, MEM_LW, v);
        check("misalign_dropped", v, 32'h1234_AA78);
        rd(8'h14, MEM_LW, v);
        check("align_err_set", v, 32'h0000_0002);
        rd(8'h19, MEM_LW, v);
        check("misalign_load_zero", v, 32'h0);
`else
        rd(8'h18, MEM_LW, v);
        check("force_align_store", v, 32'hDEAD_BEEF);
        rd(8'h14, MEM_LW, v);
        check("align_err_zero", v, 32'h0);
        rd(8'h19, MEM_LW, v);
        check("force_align_load", v, 32'hDEAD_BEEF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
